// File: rtl/tl45_pkg.sv
// Shared defaults and requester indices for the writeback arbiter.
package tl45_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

endpackage

// File: rtl/tl45_rr_arb2.sv
// Two-way round-robin grant with a 1-bit last-grant pointer; grant is combinational.
// Backpressure: no grant while reset is high; pointer moves only when a grant is issued.
module tl45_rr_arb2
    import tl45_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_idx_e  winner
);

    req_idx_e last;

    always_comb begin
        winner = REQ_ALU;
        gnt    = 2'b00;
        if (req[0] && req[1]) begin
            winner = (last == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end else if (req[1]) begin
            winner = REQ_MEM;
        end
        if (!reset && (req != 2'b00)) begin
            gnt = (winner == REQ_MEM) ? 2'b10 : 2'b01;
        end
    end

    // Reset to MEM so the ALU wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= REQ_MEM;
        end else if (gnt != 2'b00) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/tl45_wb_arbiter.sv
// ALU/load writeback arbiter with pending-register scoreboard (forwarding under TL45_WB_FWD_EN).
// Latency: register-file write 1 cycle after transfer; backpressure: ready only for the round-robin winner.
module tl45_wb_arbiter
    import tl45_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              wrREG,
    output logic [ADDR_W-1:0] writeAdd,
    output logic [DATA_W-1:0] dataI,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]        gnt;
    req_idx_e          winner;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    tl45_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({mem_valid, alu_valid}),
        .gnt    (gnt),
        .winner (winner)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign xfer      = gnt[0] | gnt[1];
    assign xfer_addr = (winner == REQ_MEM) ? mem_addr : alu_addr;
    assign xfer_data = (winner == REQ_MEM) ? mem_data : alu_data;

    // Claim is applied after the clear so a same-cycle claim keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (xfer) begin
            pending_nxt[xfer_addr] = 1'b0;
        end
        if (claim_en) begin
            pending_nxt[claim_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            wrREG    <= 1'b0;
            writeAdd <= '0;
            dataI    <= '0;
        end else begin
            pending <= pending_nxt;
            wrREG   <= xfer && (xfer_addr != '0);
            if (xfer) begin
                writeAdd <= xfer_addr;
                dataI    <= xfer_data;
            end
        end
    end

    assign busy1 = pending[chk_addr1];
    assign busy2 = pending[chk_addr2];

`ifdef TL45_WB_FWD_EN
    assign fwd_hit1  = wrREG && (writeAdd == chk_addr1) && (chk_addr1 != '0);
    assign fwd_hit2  = wrREG && (writeAdd == chk_addr2) && (chk_addr2 != '0);
    assign fwd_data1 = dataI;
    assign fwd_data2 = dataI;
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: doc/tl45_wb_arbiter.md
TL45_WB_ARBITER -- requirements
Module: tl45_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter ADDR_W, 4, register address width; address 0 is the hardwired zero register.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alu_valid / alu_ready  in/out  1/1  ALU writeback handshake (requester 0).
REQ-006 alu_addr / alu_data  in  ADDR_W/DATA_W  ALU destination register and value.
REQ-007 mem_valid / mem_ready  in/out  1/1  load writeback handshake (requester 1).
REQ-008 mem_addr / mem_data  in  ADDR_W/DATA_W  load destination register and value.
REQ-009 claim_en / claim_addr  in  1/ADDR_W  decode marks a destination register pending.
REQ-010 chk_addr1 / chk_addr2  in  ADDR_W/ADDR_W  decode source registers to hazard-check.
REQ-011 busy1 / busy2  out  1/1  the matching chk address has a pending write.
REQ-012 wrREG / writeAdd / dataI  out  1/ADDR_W/DATA_W  register-file write port, registered.
REQ-013 fwd_hit1 / fwd_hit2 / fwd_data1 / fwd_data2  out  1/1/DATA_W/DATA_W  forwarding of the in-flight write.

Function
REQ-014 A transfer occurs on a requester when valid && ready are both high at the posedge.
REQ-015 Each ready is combinational: high only for the arbitration winner; at most one ready is high per cycle.
REQ-016 Arbitration is round-robin through a 1-bit last-grant pointer; when both are valid, the winner is the requester not granted last; a lone valid requester always wins.
REQ-017 The pointer updates only on a transfer.
REQ-018 A transfer drives wrREG=1, writeAdd, dataI on the next cycle; latency is exactly 1; with no transfer, wrREG=0 the next cycle and writeAdd/dataI hold their values.
REQ-019 A transfer to address 0 completes its handshake but produces wrREG=0.
REQ-020 The scoreboard is a 2^ADDR_W-bit pending mask; bit 0 is constantly 0.
REQ-021 claim_en with a nonzero claim_addr sets that pending bit at the posedge.
REQ-022 A transfer clears the pending bit of its address at the posedge.
REQ-023 If a claim and a clear target the same address in the same cycle, the claim wins and the bit ends set.
REQ-024 busy1 = pending[chk_addr1] (combinational), and busy2 likewise; chk address 0 always gives 0.
REQ-025 A valid requester with no prior claim is legal; the clear is then a no-op.

Reset
REQ-026 While reset is high: pending mask = 0, pointer = 1 (ALU wins the first contention), wrREG = 0, writeAdd = 0, dataI = 0.
REQ-027 Both ready outputs are 0 while reset is high; requests presented during reset are not accepted and are not lost from the requester's view.
REQ-028 A reset asserted mid-operation discards the in-flight write (wrREG = 0 the next cycle) and all pending claims.

Configuration
REQ-029 Macro TL45_WB_FWD_EN compiles in forwarding.
REQ-030 With TL45_WB_FWD_EN defined: fwd_hitN = wrREG && (writeAdd == chk_addrN) && chk_addrN != 0, and fwd_dataN = dataI.
REQ-031 Without TL45_WB_FWD_EN: fwd_hit1/2 are tied 0 and fwd_data1/2 are tied 0; all other behaviour is identical.

Structure
REQ-032 Package tl45_pkg holds the DATA_W/ADDR_W defaults and the requester-index enum (REQ_ALU=0, REQ_MEM=1).
REQ-033 One sub-module, tl45_rr_arb2 (2-way round-robin grant plus pointer), is instantiated once; the scoreboard stays inline.

Verification
REQ-034 Reset; ALU only, addr 3, data 0xDEADBEEF -> alu_ready=1 the same cycle; the next cycle wrREG=1, writeAdd=3, dataI=0xDEADBEEF.
REQ-035 Both valid for 4 cycles after reset (ALU addr 1, MEM addr 2) -> grants ALU, MEM, ALU, MEM; writes land in the same order, one per cycle.
REQ-036 Claim r5, then chk_addr1=5 -> busy1=1 until the MEM write to r5 transfers; busy1=0 on the cycle after the transfer.
REQ-037 Claim r7 and an ALU write to r7 in the same cycle -> pending[7] remains 1 and busy reports 1 afterward.
REQ-038 ALU write to r0 -> alu_ready=1, wrREG=0 the next cycle, busy for r0 always 0.
REQ-039 With TL45_WB_FWD_EN: a write to r4 in flight and chk_addr2=4 -> fwd_hit2=1 and fwd_data2=dataI. Without the macro -> fwd_hit2=0. Reset asserted during the in-flight cycle -> wrREG=0 the next cycle.
